wash_timing_unit: RTL and testbench

WASH_TIMING_UNIT -- requirements
Module: wash_timing_unit

---
 rtl/wash_timing_unit.sv | 164 ++++++++++++++++
 tb/tb_wash_timing_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wash_timing_unit.sv
// Washer phase tracker: debounced level flags, tick-based wash/spin timeouts.
// Optional fill/drain watchdog enabled by defining WASH_FAULT_WATCHDOG_EN.
module wash_timing_unit #(
  parameter int unsigned CLK_PER_TICK = 100,
  parameter int unsigned WASH_TICKS   = 600,
  parameter int unsigned SPIN_TICKS   = 300,
  parameter int unsigned FULL_LEVEL   = 200,
  parameter int unsigned EMPTY_LEVEL  = 10,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned LIMIT_TICKS  = 900
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] level_raw,
  input  logic       door_lock,
  input  logic       fill_valve_on,
  input  logic       drain_valve_on,
  input  logic       motor_on,
  output logic       filled,
  output logic       drained,
  output logic       cycle_timeout,
  output logic       spin_timeout,
  output logic       fault
);

  localparam int unsigned PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam int unsigned TW = 16;
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_HOLD, S_WASH, S_DRAIN, S_SPIN
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic            cyc_to_q, cyc_to_d;
  logic            spin_to_q, spin_to_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic [DW-1:0]   full_cnt_q, full_cnt_d;
  logic [DW-1:0]   empty_cnt_q, empty_cnt_d;
  logic            clr;
  logic            tick_en;
  logic            tick_sat;
  logic            full_hit;
  logic            empty_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      tick_q      <= '0;
      cyc_to_q    <= 1'b0;
      spin_to_q   <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b0;
      full_cnt_q  <= '0;
      empty_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      cyc_to_q    <= cyc_to_d;
      spin_to_q   <= spin_to_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      full_cnt_q  <= full_cnt_d;
      empty_cnt_q <= empty_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    tick_d      = tick_q;
    cyc_to_d    = 1'b0;
    spin_to_d   = 1'b0;
    full_d      = full_q;
    empty_d     = empty_q;
    full_cnt_d  = '0;
    empty_cnt_d = '0;
    tick_sat    = 1'b0;

    // Phase sequencing; an open door aborts to IDLE from anywhere.
    if (!door_lock) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (fill_valve_on)  state_d = S_FILL;
        S_FILL:  if (!fill_valve_on) state_d = S_HOLD;
        S_HOLD: begin
          if (fill_valve_on)  state_d = S_FILL;
          else if (motor_on)  state_d = S_WASH;
        end
        S_WASH:  if (drain_valve_on) state_d = S_DRAIN;
        S_DRAIN: if (motor_on)       state_d = S_SPIN;
        S_SPIN:  if (!motor_on)      state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Counter holds once the phase's timeout (or watchdog limit) is reached.
    case (state_q)
      S_WASH:          tick_sat = (tick_q >= TW'(WASH_TICKS));
      S_SPIN:          tick_sat = (tick_q >= TW'(SPIN_TICKS));
      S_FILL, S_DRAIN: tick_sat = (tick_q >= TW'(LIMIT_TICKS));
      default:         tick_sat = (tick_q == {TW{1'b1}});
    endcase

    clr     = !door_lock || (state_d != state_q);
    tick_en = (presc_q == PW'(CLK_PER_TICK - 1));

    if (clr) begin
      presc_d = '0;
      tick_d  = '0;
    end else begin
      presc_d = tick_en ? '0 : presc_q + PW'(1);
      if (tick_en && !tick_sat) tick_d = tick_q + TW'(1);
    end

    cyc_to_d  = !clr && (state_q == S_WASH) && tick_en &&
                (tick_q == TW'(WASH_TICKS - 1));
    spin_to_d = !clr && (state_q == S_SPIN) && tick_en &&
                (tick_q == TW'(SPIN_TICKS - 1));

    // Level flags flip only after DEBOUNCE consecutive disagreeing samples.
    full_hit  = (level_raw >= 8'(FULL_LEVEL));
    empty_hit = (level_raw <= 8'(EMPTY_LEVEL));
    if (full_hit != full_q) begin
      if (full_cnt_q == DW'(DEBOUNCE - 1)) full_d = !full_q;
      else                                 full_cnt_d = full_cnt_q + DW'(1);
    end
    if (empty_hit != empty_q) begin
      if (empty_cnt_q == DW'(DEBOUNCE - 1)) empty_d = !empty_q;
      else                                  empty_cnt_d = empty_cnt_q + DW'(1);
    end
  end

`ifdef WASH_FAULT_WATCHDOG_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q |
              (((state_q == S_FILL) || (state_q == S_DRAIN)) &&
               (tick_q >= TW'(LIMIT_TICKS)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_q <= 1'b0;
    else      fault_q <= fault_d;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign filled        = full_q;
  assign drained       = empty_q;
  assign cycle_timeout = cyc_to_q;
  assign spin_timeout  = spin_to_q;

endmodule

// File: tb/tb_wash_timing_unit.sv
// Directed bench for wash_timing_unit with small timing parameters.
module tb_wash_timing_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] level_raw;
  logic       door_lock, fill_valve_on, drain_valve_on, motor_on;
  logic       filled, drained, cycle_timeout, spin_timeout, fault;

  int errors = 0;
  int checks = 0;

`ifdef WASH_FAULT_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  wash_timing_unit #(
    .CLK_PER_TICK(4), .WASH_TICKS(5), .SPIN_TICKS(3), .FULL_LEVEL(200),
    .EMPTY_LEVEL(10), .DEBOUNCE(3), .LIMIT_TICKS(8)
  ) dut (
    .clk(clk), .rst(rst), .level_raw(level_raw), .door_lock(door_lock),
    .fill_valve_on(fill_valve_on), .drain_valve_on(drain_valve_on),
    .motor_on(motor_on), .filled(filled), .drained(drained),
    .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; level_raw = 8'd100; door_lock = 1'b0;
    fill_valve_on = 1'b0; drain_valve_on = 1'b0; motor_on = 1'b0;
    #12;
    checks++;
    if ({filled, drained, cycle_timeout, spin_timeout, fault} !== 5'b0) begin
      $display("FAIL reset_outputs: got %b want 00000",
               {filled, drained, cycle_timeout, spin_timeout, fault});
      errors++;
    end
    step(); rst = 1'b1; step();
  endtask

  task automatic test_debounce();
    logic [7:0] vals [6] = '{8'd200, 8'd200, 8'd199, 8'd200, 8'd200, 8'd200};
    logic       exps [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    level_raw = 8'd150; repeat (3) step();
    checks++;
    if (filled !== 1'b0 || drained !== 1'b0) begin
      $display("FAIL deb_idle: got filled=%b drained=%b want 0 0", filled, drained);
      errors++;
    end
    level_raw = 8'd200; step(); step();
    checks++;
    if (filled !== 1'b0) begin
      $display("FAIL deb_full_early: got %b want 0", filled); errors++;
    end
    step();
    checks++;
    if (filled !== 1'b1) begin
      $display("FAIL deb_full_rise: got %b want 1", filled); errors++;
    end
    level_raw = 8'd150; step(); step();
    checks++;
    if (filled !== 1'b1) begin
      $display("FAIL deb_full_hold: got %b want 1", filled); errors++;
    end
    step();
    checks++;
    if (filled !== 1'b0) begin
      $display("FAIL deb_full_fall: got %b want 0", filled); errors++;
    end
    for (int i = 0; i < 6; i++) begin
      level_raw = vals[i]; step();
      checks++;
      if (filled !== exps[i]) begin
        $display("FAIL deb_restart[%0d]: got %b want %b", i, filled, exps[i]); errors++;
      end
    end
    level_raw = 8'd10; step(); step();
    checks++;
    if (drained !== 1'b0) begin
      $display("FAIL deb_empty_early: got %b want 0", drained); errors++;
    end
    step();
    checks++;
    if (drained !== 1'b1 || filled !== 1'b0) begin
      $display("FAIL deb_empty_rise: got drained=%b filled=%b want 1 0", drained, filled);
      errors++;
    end
    level_raw = 8'd11; repeat (3) step();
    checks++;
    if (drained !== 1'b0) begin
      $display("FAIL deb_empty_fall: got %b want 0", drained); errors++;
    end
    level_raw = 8'd100; repeat (3) step();
  endtask

  task automatic test_wash();
    logic exp;
    door_lock = 1'b1; fill_valve_on = 1'b1; step();
    fill_valve_on = 1'b0; step();
    motor_on = 1'b1; step();
    for (int k = 1; k <= 25; k++) begin
      step();
      exp = (k == 20);
      checks++;
      if (cycle_timeout !== exp || spin_timeout !== 1'b0) begin
        $display("FAIL wash_pulse k=%0d: got cyc=%b spin=%b want cyc=%b spin=0",
                 k, cycle_timeout, spin_timeout, exp);
        errors++;
      end
    end
  endtask

  task automatic test_spin();
    logic exp;
    drain_valve_on = 1'b1; motor_on = 1'b0; step();
    drain_valve_on = 1'b0; motor_on = 1'b1; step();
    for (int k = 1; k <= 16; k++) begin
      step();
      exp = (k == 12);
      checks++;
      if (spin_timeout !== exp || cycle_timeout !== 1'b0) begin
        $display("FAIL spin_pulse k=%0d: got spin=%b cyc=%b want spin=%b cyc=0",
                 k, spin_timeout, cycle_timeout, exp);
        errors++;
      end
    end
    motor_on = 1'b0; step();
  endtask

  task automatic test_abort();
    logic exp;
    door_lock = 1'b1; fill_valve_on = 1'b1; step();
    fill_valve_on = 1'b0; step();
    motor_on = 1'b1; step();
    for (int k = 1; k <= 9; k++) step();
    door_lock = 1'b0; step();
    door_lock = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      checks++;
      if (cycle_timeout !== 1'b0) begin
        $display("FAIL abort_no_pulse k=%0d: got %b want 0", k, cycle_timeout); errors++;
      end
    end
    fill_valve_on = 1'b1; step();
    fill_valve_on = 1'b0; step();
    step();
    for (int k = 1; k <= 22; k++) begin
      step();
      exp = (k == 20);
      checks++;
      if (cycle_timeout !== exp) begin
        $display("FAIL reentry_pulse k=%0d: got %b want %b", k, cycle_timeout, exp);
        errors++;
      end
    end
    motor_on = 1'b0; door_lock = 1'b0; step();
    door_lock = 1'b1; step();
  endtask

  task automatic test_watchdog();
    logic exp;
    door_lock = 1'b1; fill_valve_on = 1'b1; step();
    for (int k = 1; k <= 34; k++) begin
      step();
      exp = WD && (k >= 33);
      checks++;
      if (fault !== exp) begin
        $display("FAIL watchdog k=%0d: got %b want %b", k, fault, exp); errors++;
      end
    end
    door_lock = 1'b0; step(); step();
    checks++;
    if (fault !== WD) begin
      $display("FAIL watchdog_sticky: got %b want %b", fault, WD); errors++;
    end
    fill_valve_on = 1'b0; door_lock = 1'b1; step();
  endtask

  task automatic test_reset_mid_spin();
    level_raw = 8'd220;
    door_lock = 1'b1; fill_valve_on = 1'b1; step();
    fill_valve_on = 1'b0; step();
    motor_on = 1'b1; step();
    repeat (3) step();
    checks++;
    if (filled !== 1'b1) begin
      $display("FAIL pre_reset_filled: got %b want 1", filled); errors++;
    end
    drain_valve_on = 1'b1; motor_on = 1'b0; step();
    drain_valve_on = 1'b0; motor_on = 1'b1; step();
    repeat (6) step();
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({filled, drained, cycle_timeout, spin_timeout, fault} !== 5'b0) begin
      $display("FAIL async_reset: got %b want 00000",
               {filled, drained, cycle_timeout, spin_timeout, fault});
      errors++;
    end
    level_raw = 8'd100;
    step(); rst = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      checks++;
      if (spin_timeout !== 1'b0 || cycle_timeout !== 1'b0) begin
        $display("FAIL post_reset_idle k=%0d: got spin=%b cyc=%b want 0 0",
                 k, spin_timeout, cycle_timeout);
        errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_wash();
    test_spin();
    test_abort();
    test_watchdog();
    test_reset_mid_spin();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
